uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

- Command controller directly downstream of the UART receiver.
- Consumes the receiver's byte stream (parallel data, valid pulse, parity/stop error flags).
- Decodes byte-level write and read commands, then drives a register-file port.
- For reads, returns the fetched byte to the transmit path through a valid/busy handshake.

## Interface

Parameters:
- DATA_WIDTH, 8, width of received bytes, register data and TX data
- ADDR_WIDTH, 4, register-file address width; the low ADDR_WIDTH bits of the address byte are used, upper bits ignored
- TIMEOUT, 1023, idle cycles allowed between command bytes (or waiting for read data) before abort

Ports:
- CLK  in  1  system clock; one clock for the whole block
- RST  in  1  reset, asynchronous, active-low
- RX_P_DATA  in  DATA_WIDTH  received byte from UART receiver
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
- RX_PAR_ERR  in  1  receiver parity error flag
- RX_STP_ERR  in  1  receiver stop-bit error flag
- RF_ADDR  out  ADDR_WIDTH  register-file address
- RF_WR_EN  out  1  one-cycle write strobe
- RF_WR_DATA  out  DATA_WIDTH  write data
- RF_RD_EN  out  1  one-cycle read strobe
- RF_RD_DATA  in  DATA_WIDTH  read data
- RF_RD_VLD  in  1  read data valid, any cycle after RF_RD_EN
- TX_DATA  out  DATA_WIDTH  byte to transmit
- TX_VLD  out  1  TX_DATA valid, held until accepted
- TX_BUSY  in  1  transmitter busy; transfer occurs in a cycle with TX_VLD=1 and TX_BUSY=0
- CMD_ERR  out  1  one-cycle pulse, command aborted or rejected

## Operation

Opcodes:
- 0xAA write: three bytes — opcode, address, data.
- 0xBB read: two bytes — opcode, address.

States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE:
  - RX_D_VLD with 0xAA → WR_ADDR.
  - RX_D_VLD with 0xBB → RD_ADDR.
  - Any other byte → CMD_ERR pulse, stay IDLE.
- WR_ADDR: on byte, latch RF_ADDR → WR_DATA.
- WR_DATA: on byte, latch RF_WR_DATA, RF_WR_EN=1 for one cycle → IDLE.
- RD_ADDR: on byte, latch RF_ADDR, RF_RD_EN=1 for one cycle → RD_WAIT.
- RD_WAIT: on RF_RD_VLD, capture RF_RD_DATA into TX_DATA, set TX_VLD → TX_SEND.
- TX_SEND: when TX_BUSY=0, clear TX_VLD → IDLE.

Receive errors:
- In IDLE, WR_ADDR, WR_DATA or RD_ADDR, a cycle with RX_PAR_ERR or RX_STP_ERR high causes a CMD_ERR pulse and a return to IDLE.
- Any partially collected command is discarded; no RF strobe is issued.
- If an error coincides with RX_D_VLD, the error wins and the byte is dropped.

Timeout:
- Counter clears on entry to WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT and on every accepted RX_D_VLD.
- When the counter reaches TIMEOUT in any of those states: CMD_ERR pulse → IDLE.
- Counter width is ceil(log2(TIMEOUT+1)) bits and saturates (no wrap).

Ignored inputs:
- In RD_WAIT and TX_SEND, RX_D_VLD, RX_PAR_ERR and RX_STP_ERR are ignored; bytes are dropped with no error.
- RF_RD_VLD outside RD_WAIT is ignored.

## Timing

- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE and the counter to 0.
- Reset asserted mid-command: immediate return to IDLE, strobes and TX_VLD drop asynchronously.
- RF_WR_EN / RF_RD_EN are high exactly one cycle, in the cycle after the RX_D_VLD of the final command byte.
- RF_ADDR and RF_WR_DATA are valid in that same cycle and held until next updated.
- TX_VLD and TX_DATA rise the cycle after RF_RD_VLD.
  - TX_DATA is stable while TX_VLD=1.
  - TX_VLD falls the cycle after the first TX_VLD=1 & TX_BUSY=0 cycle.
  - Minimum TX_VLD width is one cycle.
- CMD_ERR is high exactly one cycle, the cycle after the triggering event (bad opcode, RX error, counter reaching TIMEOUT).
- Back-to-back commands: an opcode arriving in the cycle immediately after a write completes (state IDLE) is accepted.

## Test plan

- Write: bytes AA, 05, 3C with 4-cycle gaps → one RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=0x3C, CMD_ERR never high.
- Read with busy TX: bytes BB, 0A, then RF_RD_DATA=0x5A with RF_RD_VLD 3 cycles after RF_RD_EN, TX_BUSY=1 for 10 cycles → one RF_RD_EN with RF_ADDR=0xA; TX_VLD=1 and TX_DATA=0x5A held 10+ cycles, drop the cycle after TX_BUSY falls.
- Bad opcode 0x12, then AA, 01, FF → CMD_ERR one pulse after 0x12; subsequent write completes with RF_ADDR=1, RF_WR_DATA=0xFF.
- AA, 02, then RX_PAR_ERR pulse coinciding with data byte 0x77 → CMD_ERR pulse, no RF_WR_EN; following BB, 02 performs a normal read.
- TIMEOUT=20: AA then silence → CMD_ERR exactly once, 20 cycles after the counter clears, back in IDLE; a byte 0x55 arriving afterwards gives another CMD_ERR (bad opcode).
- Read in progress (RD_WAIT): bytes AA, 01, 02 delivered before RF_RD_VLD → bytes ignored, no RF_WR_EN, read completes normally; RST pulse mid-TX_SEND clears TX_VLD immediately.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART byte-command decoder driving a register-file port and a TX read-back path
module uart_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_ERR,
    input  logic                  RX_STP_ERR,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic                  RF_WR_EN,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  RF_RD_EN,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_VLD,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VLD,
    input  logic                  TX_BUSY,
    output logic                  CMD_ERR
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  err_q, err_d;
    logic                  rx_err;
    logic                  timed_out;

    assign rx_err    = RX_PAR_ERR | RX_STP_ERR;
    assign timed_out = (cnt_q == TO_CNT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = timed_out ? cnt_q : cnt_q + 1'b1;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_err) begin
                    err_d = 1'b1;
                end else if (RX_D_VLD) begin
                    if (RX_P_DATA == OP_WR)      state_d = WR_ADDR;
                    else if (RX_P_DATA == OP_RD) state_d = RD_ADDR;
                    else                         err_d   = 1'b1;
                end
            end
            WR_ADDR, WR_DATA, RD_ADDR: begin
                // An error on the same cycle as a byte wins: the byte is dropped.
                if (rx_err || (!RX_D_VLD && timed_out)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (RX_D_VLD) begin
                    cnt_d = '0;
                    case (state_q)
                        WR_ADDR: begin
                            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                            state_d = WR_DATA;
                        end
                        WR_DATA: begin
                            wr_data_d = RX_P_DATA;
                            wr_en_d   = 1'b1;
                            state_d   = IDLE;
                        end
                        default: begin
                            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                            rd_en_d = 1'b1;
                            state_d = RD_WAIT;
                        end
                    endcase
                end
            end
            RD_WAIT: begin
                if (RF_RD_VLD) begin
                    tx_data_d = RF_RD_DATA;
                    tx_vld_d  = 1'b1;
                    state_d   = TX_SEND;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            TX_SEND: begin
                cnt_d = '0;
                if (!TX_BUSY) begin
                    tx_vld_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign RF_ADDR    = addr_q;
    assign RF_WR_EN   = wr_en_q;
    assign RF_WR_DATA = wr_data_q;
    assign RF_RD_EN   = rd_en_q;
    assign TX_DATA    = tx_data_q;
    assign TX_VLD     = tx_vld_q;
    assign CMD_ERR    = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_vld = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic [3:0] rf_addr;
    logic       rf_wr_en;
    logic [7:0] rf_wr_data;
    logic       rf_rd_en;
    logic [7:0] rf_rd_data = 8'h00;
    logic       rf_rd_vld = 1'b0;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_busy = 1'b0;
    logic       cmd_err;

    int n_vec = 0;
    int n_err = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int err_pulses = 0;

    uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(20)) dut (
        .CLK(clk), .RST(rst_n),
        .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld), .RX_PAR_ERR(par_err), .RX_STP_ERR(stp_err),
        .RF_ADDR(rf_addr), .RF_WR_EN(rf_wr_en), .RF_WR_DATA(rf_wr_data), .RF_RD_EN(rf_rd_en),
        .RF_RD_DATA(rf_rd_data), .RF_RD_VLD(rf_rd_vld),
        .TX_DATA(tx_data), .TX_VLD(tx_vld), .TX_BUSY(tx_busy), .CMD_ERR(cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_wr_en) wr_pulses++;
        if (rf_rd_en) rd_pulses++;
        if (cmd_err)  err_pulses++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge right after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_vld  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        n_vec++;
        if ({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, tx_data, tx_vld, cmd_err} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, tx_data, tx_vld, cmd_err});
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write;
        int w0, e0;
        w0 = wr_pulses; e0 = err_pulses;
        send_byte(8'hAA); idle(4);
        send_byte(8'h05); idle(4);
        send_byte(8'h3C);
        n_vec++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h5, 8'h3C}) begin
            n_err++;
            $display("FAIL write_strobe: got en=%b addr=%h data=%h expected en=1 addr=5 data=3c",
                     rf_wr_en, rf_addr, rf_wr_data);
        end
        idle(2);
        n_vec++;
        if ((wr_pulses - w0) !== 1 || (err_pulses - e0) !== 0) begin
            n_err++;
            $display("FAIL write_counts: got wr=%0d err=%0d expected wr=1 err=0",
                     wr_pulses - w0, err_pulses - e0);
        end
    endtask

    task automatic test_read_busy;
        int r0, bad;
        r0 = rd_pulses; bad = 0;
        tx_busy = 1'b1;
        send_byte(8'hBB); idle(4);
        send_byte(8'h0A);
        n_vec++;
        if ({rf_rd_en, rf_addr} !== {1'b1, 4'hA}) begin
            n_err++;
            $display("FAIL read_strobe: got en=%b addr=%h expected en=1 addr=a", rf_rd_en, rf_addr);
        end
        idle(2);
        @(negedge clk);
        rf_rd_data = 8'h5A; rf_rd_vld = 1'b1;
        @(negedge clk);
        rf_rd_vld = 1'b0; rf_rd_data = 8'h00;
        n_vec++;
        if ({tx_vld, tx_data} !== {1'b1, 8'h5A}) begin
            n_err++;
            $display("FAIL tx_rise: got vld=%b data=%h expected vld=1 data=5a", tx_vld, tx_data);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({tx_vld, tx_data} !== {1'b1, 8'h5A}) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL tx_hold_busy: got %0d unstable cycles expected 0", bad);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        n_vec++;
        if (tx_vld !== 1'b0) begin
            n_err++;
            $display("FAIL tx_drop: got vld=%b expected 0", tx_vld);
        end
        idle(2);
        n_vec++;
        if ((rd_pulses - r0) !== 1) begin
            n_err++;
            $display("FAIL read_count: got %0d expected 1", rd_pulses - r0);
        end
    endtask

    task automatic test_bad_opcode;
        int e0;
        e0 = err_pulses;
        send_byte(8'h12);
        n_vec++;
        if (cmd_err !== 1'b1) begin
            n_err++;
            $display("FAIL bad_opcode_err: got %b expected 1", cmd_err);
        end
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'hFF);
        n_vec++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h1, 8'hFF}) begin
            n_err++;
            $display("FAIL write_after_bad: got en=%b addr=%h data=%h expected en=1 addr=1 data=ff",
                     rf_wr_en, rf_addr, rf_wr_data);
        end
        idle(2);
        n_vec++;
        if ((err_pulses - e0) !== 1) begin
            n_err++;
            $display("FAIL bad_opcode_count: got %0d expected 1", err_pulses - e0);
        end
    endtask

    task automatic test_rx_error;
        int w0, e0;
        w0 = wr_pulses; e0 = err_pulses;
        send_byte(8'hAA);
        send_byte(8'h02);
        @(negedge clk);
        rx_data = 8'h77; rx_vld = 1'b1; par_err = 1'b1;
        @(negedge clk);
        rx_vld = 1'b0; par_err = 1'b0;
        n_vec++;
        if ({cmd_err, rf_wr_en} !== 2'b10) begin
            n_err++;
            $display("FAIL par_err_abort: got err=%b wr_en=%b expected err=1 wr_en=0", cmd_err, rf_wr_en);
        end
        send_byte(8'hBB);
        send_byte(8'h02);
        n_vec++;
        if ({rf_rd_en, rf_addr} !== {1'b1, 4'h2}) begin
            n_err++;
            $display("FAIL read_after_err: got en=%b addr=%h expected en=1 addr=2", rf_rd_en, rf_addr);
        end
        @(negedge clk);
        rf_rd_data = 8'h66; rf_rd_vld = 1'b1;
        @(negedge clk);
        rf_rd_vld = 1'b0;
        n_vec++;
        if ({tx_vld, tx_data} !== {1'b1, 8'h66}) begin
            n_err++;
            $display("FAIL read_after_err_tx: got vld=%b data=%h expected vld=1 data=66", tx_vld, tx_data);
        end
        @(negedge clk);
        n_vec++;
        if (tx_vld !== 1'b0) begin
            n_err++;
            $display("FAIL tx_min_width: got vld=%b expected 0", tx_vld);
        end
        idle(2);
        n_vec++;
        if ((wr_pulses - w0) !== 0 || (err_pulses - e0) !== 1) begin
            n_err++;
            $display("FAIL rx_error_counts: got wr=%0d err=%0d expected wr=0 err=1",
                     wr_pulses - w0, err_pulses - e0);
        end
    endtask

    // Counter is 0 in the cycle after the opcode edge and hits 20 after 20 more edges;
    // CMD_ERR is registered one edge later, so it is seen after edge 21.
    task automatic test_timeout;
        int first, hits;
        first = -1; hits = 0;
        send_byte(8'hAA);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (cmd_err === 1'b1) begin
                hits++;
                if (first < 0) first = k;
            end
        end
        n_vec++;
        if (first !== 21 || hits !== 1) begin
            n_err++;
            $display("FAIL timeout_err: got first=%0d hits=%0d expected first=21 hits=1", first, hits);
        end
        send_byte(8'h55);
        n_vec++;
        if (cmd_err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_then_bad: got %b expected 1", cmd_err);
        end
        idle(2);
    endtask

    task automatic test_ignore_rd_wait;
        int w0, e0;
        w0 = wr_pulses; e0 = err_pulses;
        tx_busy = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'h01);
        @(negedge clk);
        rx_data = 8'h02; rx_vld = 1'b1; stp_err = 1'b1;
        @(negedge clk);
        rx_vld = 1'b0; stp_err = 1'b0;
        @(negedge clk);
        rf_rd_data = 8'hC3; rf_rd_vld = 1'b1;
        @(negedge clk);
        rf_rd_vld = 1'b0;
        n_vec++;
        if ({tx_vld, tx_data} !== {1'b1, 8'hC3}) begin
            n_err++;
            $display("FAIL rd_wait_read: got vld=%b data=%h expected vld=1 data=c3", tx_vld, tx_data);
        end
        n_vec++;
        if ((wr_pulses - w0) !== 0 || (err_pulses - e0) !== 0) begin
            n_err++;
            $display("FAIL rd_wait_ignored: got wr=%0d err=%0d expected wr=0 err=0",
                     wr_pulses - w0, err_pulses - e0);
        end
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({tx_vld, tx_data} !== 9'd0) begin
            n_err++;
            $display("FAIL async_reset_tx: got vld=%b data=%h expected vld=0 data=00", tx_vld, tx_data);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_back_to_back;
        int w0, e0;
        logic [7:0] seq [6];
        w0 = wr_pulses; e0 = err_pulses;
        seq = '{8'hAA, 8'h03, 8'h11, 8'hAA, 8'h04, 8'h22};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rx_data = seq[i];
            rx_vld  = 1'b1;
        end
        @(negedge clk);
        rx_vld = 1'b0;
        n_vec++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h4, 8'h22}) begin
            n_err++;
            $display("FAIL b2b_second_write: got en=%b addr=%h data=%h expected en=1 addr=4 data=22",
                     rf_wr_en, rf_addr, rf_wr_data);
        end
        idle(2);
        n_vec++;
        if ((wr_pulses - w0) !== 2 || (err_pulses - e0) !== 0) begin
            n_err++;
            $display("FAIL b2b_counts: got wr=%0d err=%0d expected wr=2 err=0",
                     wr_pulses - w0, err_pulses - e0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_busy();
        test_bad_opcode();
        test_rx_error();
        test_timeout();
        test_ignore_rd_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
